// File: rtl/sr_hypot_unit.sv
// Multi-cycle hypot responder: out = floor(sqrt(a^2 + b^2)), with every add,
// subtract and compare executed on the CPU's shared 32-bit ALU.
module sr_hypot_unit #(
  parameter int W_OP = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W_OP-1:0] a,
  input  logic [W_OP-1:0] b,
  input  logic [31:0]     aluResult,
  output logic [2:0]      aluOper,
  output logic [31:0]     aluSrcA,
  output logic [31:0]     aluSrcB,
  output logic [W_OP:0]   out,
  output logic            ready
);

  localparam int W_SQ  = 2 * W_OP + 1;
  localparam int W_CNT = (W_OP > 1) ? $clog2(W_OP) : 1;

  // Operation encodings shared with the CPU's ALU.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_SQA, S_SQB, S_SUM, S_RADD, S_RCMP, S_RSUB, S_DONE
  } state_t;

  state_t            r_state;
  logic [W_OP-1:0]   r_a_l;
  logic [W_OP-1:0]   r_b_l;
  logic [W_SQ-1:0]   r_acc;
  logic [W_SQ-1:0]   r_num;
  logic [W_SQ-1:0]   r_res;
  logic [W_SQ-1:0]   r_bit;
  logic [W_SQ-1:0]   r_t;
  logic              r_lt;
  logic [W_CNT-1:0]  r_cnt;
  logic [W_OP:0]     r_out;
  logic              r_ready;

  logic [W_SQ-1:0]   w_alu_res;
  logic [W_OP-1:0]   w_sq_op;
  logic              w_cnt_last;
  logic [W_SQ-1:0]   w_res_next;

  assign w_alu_res  = aluResult[W_SQ-1:0];
  assign w_sq_op    = (r_state == S_SQB) ? r_b_l : r_a_l;
  assign w_cnt_last = (r_cnt == W_CNT'(W_OP - 1));
  // The partial root sits shifted left while bits are being resolved, so it
  // needs the full square width even though only W_OP+1 bits survive.
  assign w_res_next = r_lt ? (r_res >> 1) : ((r_res >> 1) | r_bit);

  assign out   = r_out;
  assign ready = r_ready;

  // ALU lines depend on state and registers only, keeping aluResult out of
  // any combinational path back into the ALU.
  // NOTE: every output gets a default before the case, so no latch is inferred.
  always_comb begin
    aluOper = ALU_ADD;
    aluSrcA = '0;
    aluSrcB = '0;
    case (r_state)
      S_SQA, S_SQB: begin
        aluSrcA = 32'(r_acc);
        aluSrcB = w_sq_op[r_cnt] ? (32'(w_sq_op) << r_cnt) : '0;
      end
      S_SUM: begin
        aluSrcA = 32'(r_num);
        aluSrcB = 32'(r_acc);
      end
      S_RADD: begin
        aluSrcA = 32'(r_res);
        aluSrcB = 32'(r_bit);
      end
      S_RCMP: begin
        aluOper = ALU_SLTU;
        aluSrcA = 32'(r_num);
        aluSrcB = 32'(r_t);
      end
      S_RSUB: begin
        aluOper = ALU_SUB;
        aluSrcA = 32'(r_num);
        aluSrcB = 32'(r_t);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_l   <= '0;
      r_b_l   <= '0;
      r_acc   <= '0;
      r_num   <= '0;
      r_res   <= '0;
      r_bit   <= '0;
      r_t     <= '0;
      r_lt    <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (start) begin
            r_a_l   <= a;
            r_b_l   <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= S_SQA;
          end
        end
        S_SQA: begin
          r_acc <= w_alu_res;
          r_cnt <= r_cnt + 1'b1;
          if (w_cnt_last) begin
            r_num   <= w_alu_res;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_SQB;
          end
        end
        S_SQB: begin
          // b^2 stays in acc; SUM folds it into num.
          r_acc <= w_alu_res;
          r_cnt <= r_cnt + 1'b1;
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= S_SUM;
          end
        end
        S_SUM: begin
          r_num   <= w_alu_res;
          r_bit   <= W_SQ'(1) << (W_SQ - 1);
          r_res   <= '0;
          r_state <= S_RADD;
        end
        S_RADD: begin
          r_t     <= w_alu_res;
          r_state <= S_RCMP;
        end
        S_RCMP: begin
          r_lt    <= aluResult[0];
          r_state <= S_RSUB;
        end
        S_RSUB: begin
          if (!r_lt) r_num <= w_alu_res;
          r_res <= w_res_next;
          r_bit <= r_bit >> 2;
          if (r_bit == W_SQ'(1)) begin
            r_out   <= w_res_next[W_OP:0];
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RADD;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_hypot_unit.sv
// Bench for sr_hypot_unit: behavioural ALU plus an integer-sqrt reference
// model checked every cycle, with directed vectors carrying literal results.
module tb_sr_hypot_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [31:0] aluResult;
  logic [2:0]  aluOper;
  logic [31:0] aluSrcA;
  logic [31:0] aluSrcB;
  logic [8:0]  out;
  logic        ready;

  int checks = 0;
  int errors = 0;

  sr_hypot_unit #(.W_OP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .aluResult (aluResult),
    .aluOper   (aluOper),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .out       (out),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Shared CPU ALU.
  always_comb begin
    aluResult = '0;
    case (aluOper)
      3'b000: aluResult = aluSrcA + aluSrcB;
      3'b100: aluResult = aluSrcA - aluSrcB;
      3'b011: aluResult = {31'd0, (aluSrcA < aluSrcB)};
      default: aluResult = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Reference model: position within the 46-cycle transaction (0 = idle).
  int m_phase = 0;
  int m_pend  = 0;
  int m_out   = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_out   <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_pend  <= isqrt(int'(a) * int'(a) + int'(b) * int'(b));
        end
      end else if (m_phase == 45) begin
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
        if (m_phase == 44) m_out <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready_model", 32'(ready), 32'(m_phase == 45));
      check("out_model", 32'(out), 32'(m_out));
      check("srcA_range", aluSrcA >> 17, 32'd0);
      check("srcB_range", aluSrcB >> 17, 32'd0);
      check("oper_legal", 32'(aluOper == 3'b000 || aluOper == 3'b011 || aluOper == 3'b100), 32'd1);
    end
  end

  // Called at a negedge whose cycle index is 'from'; waits for ready.
  task automatic wait_ready(input string name, input int from, input int exp_cyc, input int exp_out);
    int cyc = -1;
    for (int i = from + 1; i <= from + 80; i++) begin
      @(negedge clk);
      if (ready) begin
        cyc = i;
        break;
      end
    end
    check({name, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_out"}, 32'(out), 32'(exp_out));
  endtask

  task automatic single_op(input string name, input logic [7:0] ia, input logic [7:0] ib, input int exp_out);
    start = 1'b1;
    a     = ia;
    b     = ib;
    wait_ready(name, 0, 45, exp_out);
    start = 1'b0;
    @(negedge clk);
    check({name, "_ready_c46"}, 32'(ready), 32'd0);
    check({name, "_out_hold"}, 32'(out), 32'(exp_out));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_oper", 32'(aluOper), 32'd0);
    check("rst_srcA", aluSrcA, 32'd0);
    check("rst_srcB", aluSrcB, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    single_op("h3_4", 8'd3, 8'd4, 5);
    single_op("h0_0", 8'd0, 8'd0, 0);
    single_op("h1_0", 8'd1, 8'd0, 1);
    single_op("h0_7", 8'd0, 8'd7, 7);
    single_op("h255_255", 8'd255, 8'd255, 360);

    // Back-to-back with start held across the DONE boundary.
    start = 1'b1;
    a = 8'd5;
    b = 8'd12;
    wait_ready("b2b_first", 0, 45, 13);
    a = 8'd8;
    b = 8'd15;
    wait_ready("b2b_second", 45, 91, 17);
    start = 1'b0;
    @(negedge clk);

    // Operands change mid-operation; the latched values must be used.
    start = 1'b1;
    a = 8'd6;
    b = 8'd8;
    repeat (10) @(negedge clk);
    a = 8'd200;
    b = 8'd200;
    wait_ready("latched", 10, 45, 10);
    start = 1'b0;
    @(negedge clk);

    // Reset mid-operation, then restart.
    start = 1'b1;
    a = 8'd100;
    b = 8'd50;
    repeat (20) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_oper", 32'(aluOper), 32'd0);
    check("midrst_srcA", aluSrcA, 32'd0);
    check("midrst_srcB", aluSrcB, 32'd0);
    rst = 1'b0;
    single_op("h9_12", 8'd9, 8'd12, 15);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
